// File: rtl/hw2_seq_div.sv
// hw2_seq_div: multi-cycle unsigned restoring divider, d = q*c + r.
// Recovers the quotient and remainder of a DW-bit dividend by a CW-bit
// divisor, one quotient bit per clock, MSB first.  A zero divisor skips
// the iteration and returns q = all ones, r = low CW bits of d, div_zero = 1.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  ready to accept operands (high only in IDLE)
//   d          in   DW-bit dividend
//   c          in   CW-bit divisor
//   out_valid  out  result valid (high only in DONE)
//   out_ready  in   consumer accepts the result
//   q          out  DW-bit quotient
//   r          out  CW-bit remainder
//   div_zero   out  result came from a zero divisor
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// RUN   | producing one quotient bit per cycle
// DONE  | result presented, held until out_ready

module hw2_seq_div #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  input  logic [CW-1:0] c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [CW-1:0] r,
  output logic          div_zero
);

  localparam int CNTW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dq_q, dq_d;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [CW-1:0]   pr_q, pr_d;     // stored remainder is always < c, so CW bits suffice
  logic [CW-1:0]   c_q, c_d;
  logic [DW-1:0]   q_q, q_d;
  logic [CW-1:0]   r_q, r_d;
  logic            dz_q, dz_d;

  logic [CW:0]     pr_sh;
  logic            ge;
  logic [CW-1:0]   pr_sub;
  logic [CW-1:0]   pr_nxt;
  logic [DW-1:0]   dq_nxt;

  // One restoring step.  The subtraction only needs CW bits: when ge holds
  // the true difference is below c and therefore fits.
  always_comb begin
    pr_sh  = {pr_q, dq_q[DW-1]};
    ge     = (pr_sh >= {1'b0, c_q});
    pr_sub = pr_sh[CW-1:0] - c_q;
    pr_nxt = ge ? pr_sub : pr_sh[CW-1:0];
    dq_nxt = {dq_q[DW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    pr_d    = pr_q;
    c_d     = c_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dq_d  = d;
          c_d   = c;
          pr_d  = '0;
          cnt_d = CNTW'(DW - 1);
          if (c == '0) begin
            q_d     = '1;
            r_d     = d[CW-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dq_d  = dq_nxt;
        pr_d  = pr_nxt;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == '0) begin
          q_d     = dq_nxt;
          r_d     = pr_nxt;
          dz_d    = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      pr_q    <= '0;
      c_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      pr_q    <= pr_d;
      c_q     <= c_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_hw2_seq_div.sv
module tb_hw2_seq_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] d;
  logic [7:0]  c;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  hw2_seq_div #(.DW(16), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  c;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for out_valid, sampling on falling edges.  lat counts the
  // rising edges after the accept edge before out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] dd, input logic [7:0] cc, input logic ordy,
                        output logic [15:0] qo, output logic [7:0] ro,
                        output logic dzo, output int lat);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    d         = dd;
    c         = cc;
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    d        = 16'($urandom);
    c        = 8'($urandom);
    wait_valid(lat);
    qo  = q;
    ro  = r;
    dzo = div_zero;
    if (ordy) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
      chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] qo;
    logic [7:0]  ro;
    logic        dzo;
    int          lat;
    logic [15:0] a, b, dd;
    logic [7:0]  cc;
    logic        s;
    int          bad0;

    vecs[0] = '{16'h1234, 8'h10, 16'h0123, 8'h04, 1'b0, 16};
    vecs[1] = '{16'hABCD, 8'h00, 16'hFFFF, 8'hCD, 1'b1, 0};
    vecs[2] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16};
    vecs[3] = '{16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0, 16};
    vecs[4] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 16};
    vecs[5] = '{16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0, 16};
    vecs[6] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 16};
    vecs[7] = '{16'h0007, 8'h00, 16'hFFFF, 8'h07, 1'b1, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = 16'h0;
    c         = 8'h0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_q",         {16'd0, q}, 32'd0);
    chk("rst_r",         {24'd0, r}, 32'd0);
    chk("rst_div_zero",  {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].d, vecs[i].c, 1'b1, qo, ro, dzo, lat);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_q", i), {16'd0, qo}, {16'd0, vecs[i].exp_q});
      chk($sformatf("vec%0d_r", i), {24'd0, ro}, {24'd0, vecs[i].exp_r});
      chk($sformatf("vec%0d_dz", i), {31'd0, dzo}, {31'd0, vecs[i].exp_dz});
    end

    // Backpressure: hold DONE with new operands waiting on the input.
    run_op(16'h1234, 8'h10, 1'b0, qo, ro, dzo, lat);
    chk("bp_lat", lat, 16);
    chk("bp_q", {16'd0, qo}, 32'h0123);
    in_valid = 1'b1;
    d        = 16'h0100;
    c        = 8'h03;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_q", {16'd0, q}, 32'h0123);
      chk("bp_hold_r", {24'd0, r}, 32'h04);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    d        = 16'hDEAD;
    c        = 8'h00;
    wait_valid(lat);
    chk("bp2_lat", lat, 16);
    chk("bp2_q", {16'd0, q}, 32'h0055);
    chk("bp2_r", {24'd0, r}, 32'h01);
    chk("bp2_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of RUN; q holds 0x0055 beforehand.
    in_valid = 1'b1;
    d        = 16'h1234;
    c        = 8'h10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_q", {16'd0, q}, 32'd0);
    chk("mid_rst_r", {24'd0, r}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1234, 8'h10, 1'b1, qo, ro, dzo, lat);
    chk("after_rst_lat", lat, 16);
    chk("after_rst_q", {16'd0, qo}, 32'h0123);
    chk("after_rst_r", {24'd0, ro}, 32'h04);

    // Round trip against plain integer division.
    for (int i = 0; i < 200; i++) begin
      bad0 = bad;
      a  = 16'($urandom);
      b  = 16'($urandom);
      s  = 1'($urandom);
      cc = (i % 2 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      dd = s ? 16'((a + b) * cc) : 16'((a - b) * cc);
      run_op(dd, cc, 1'b1, qo, ro, dzo, lat);
      if (cc == 8'h00) begin
        chk("rt_lat0", lat, 0);
        chk("rt_q0", {16'd0, qo}, 32'hFFFF);
        chk("rt_r0", {24'd0, ro}, {24'd0, dd[7:0]});
        chk("rt_dz0", {31'd0, dzo}, 32'd1);
      end else begin
        chk("rt_lat", lat, 16);
        chk("rt_recon", 32'(qo) * 32'(cc) + 32'(ro), 32'(dd));
        chk("rt_r_lt_c", {31'd0, (ro < cc)}, 32'd1);
        chk("rt_q", {16'd0, qo}, 32'(dd) / 32'(cc));
        chk("rt_dz", {31'd0, dzo}, 32'd0);
      end
      if (bad != bad0) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
